// File: rtl/dekatron_pkg.sv
// dekatron_pkg: shared constants and types for the dekatron step emulation.
//   DEK_POSITIONS - number of glow positions in the tube
//   DEK_ZERO/NINE - one-hot codes of the two wrap-around positions
//   dek_state_e   - step sequencer states
//   G_NONE/G1/G2  - guide electrode drive codes (bit0 = G1, bit1 = G2)
//   is_onehot()   - true when exactly one bit of a position vector is set
package dekatron_pkg;

    localparam int unsigned DEK_POSITIONS = 10;

    localparam logic [DEK_POSITIONS-1:0] DEK_ZERO = 10'b0000000001;
    localparam logic [DEK_POSITIONS-1:0] DEK_NINE = 10'b1000000000;

    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        DONE
    } dek_state_e;

    localparam logic [1:0] G_NONE = 2'b00;
    localparam logic [1:0] G1     = 2'b01;
    localparam logic [1:0] G2     = 2'b10;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [DEK_POSITIONS-1:0] v);
        return (v != '0) && ((v & (v - DEK_ZERO)) == '0);
    endfunction

endpackage

// File: rtl/dekatron_ring.sv
// dekatron_ring: combinational one-position rotate of the one-hot glow ring.
//   pos      - current one-hot position
//   dec      - 0 = move toward higher index, 1 = toward lower index
//   next_pos - rotated one-hot position
//   wrap     - set when the move crosses between position 9 and position 0
module dekatron_ring
    import dekatron_pkg::*;
(
    input  logic [DEK_POSITIONS-1:0] pos,
    input  logic                     dec,
    output logic [DEK_POSITIONS-1:0] next_pos,
    output logic                     wrap
);

    always_comb begin
        next_pos = pos;
        wrap     = 1'b0;
        if (dec) begin
            next_pos = {pos[0], pos[DEK_POSITIONS-1:1]};
            wrap     = (pos == DEK_ZERO);
        end else begin
            next_pos = {pos[DEK_POSITIONS-2:0], pos[DEK_POSITIONS-1]};
            wrap     = (pos == DEK_NINE);
        end
    end

endmodule

// File: rtl/dekatron_step.sv
// dekatron_step: one dekatron counting tube with a timed two-phase guide drive.
//   Clk     - system clock, rising edge
//   Rst     - asynchronous active-high reset (glow returns to position 0)
//   Request - start one step (accepted only when idle)
//   Dec     - step direction captured with Request: 0 = up, 1 = down
//   Set     - load In as the glow position (accepted only when idle, wins over Request)
//   In      - one-hot load value; anything not one-hot loads position 0
//   Out     - one-hot glow position
//   Guide   - guide electrode drive, bit0 = G1, bit1 = G2
//   Busy    - high while the guide phases run
//   Ready   - one-cycle pulse when a step lands
//   Zero    - high while Out is position 0
//   Carry   - one-cycle pulse with Ready when the step wrapped 9<->0
module dekatron_step
    import dekatron_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Request,
    input  logic                     Dec,
    input  logic                     Set,
    input  logic [DEK_POSITIONS-1:0] In,
    output logic [DEK_POSITIONS-1:0] Out,
    output logic [1:0]               Guide,
    output logic                     Busy,
    output logic                     Ready,
    output logic                     Zero,
    output logic                     Carry
);

    localparam int unsigned CNT_W = $clog2(PULSE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dek_state_e               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     dec_q, dec_d;
    logic [DEK_POSITIONS-1:0] out_q, out_d;
    logic                     zero_q, zero_d;
    logic                     ready_q, ready_d;
    logic                     carry_q, carry_d;

    logic [DEK_POSITIONS-1:0] ring_next;
    logic                     ring_wrap;
    logic [1:0]               guide_c;
    logic                     busy_c;

    dekatron_ring u_ring (
        .pos      (out_q),
        .dec      (dec_q),
        .next_pos (ring_next),
        .wrap     (ring_wrap)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        out_d   = out_q;
        ready_d = 1'b0;
        carry_d = 1'b0;
        guide_c = G_NONE;
        busy_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Set) begin
                    out_d = is_onehot(In) ? In : DEK_ZERO;
                end else if (Request) begin
                    dec_d   = Dec;
                    cnt_d   = '0;
                    state_d = PH1;
                end
            end
            PH1: begin
                guide_c = dec_q ? G2 : G1;
                busy_c  = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = PH2;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PH2: begin
                guide_c = dec_q ? G1 : G2;
                busy_c  = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    // The glow lands on the edge that enters DONE, so Out,
                    // Ready and Carry all become visible together.
                    out_d   = ring_next;
                    ready_d = 1'b1;
                    carry_d = ring_wrap;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        zero_d = (out_d == DEK_ZERO);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            out_q   <= DEK_ZERO;
            zero_q  <= 1'b1;
            ready_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            ready_q <= ready_d;
            carry_q <= carry_d;
        end
    end

    // Guide and Busy decode straight from the state register so an
    // asynchronous reset removes the drive without waiting for a clock.
    assign Out   = out_q;
    assign Zero  = zero_q;
    assign Ready = ready_q;
    assign Carry = carry_q;
    assign Guide = guide_c;
    assign Busy  = busy_c;

endmodule

// File: tb/tb_dekatron_step.sv
module tb_dekatron_step;

    localparam int P = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, PULSE_CYCLES = 4
    logic       rst = 1'b1, req = 1'b0, dec = 1'b0, set = 1'b0;
    logic [9:0] din = '0;
    logic [9:0] out;
    logic [1:0] guide;
    logic       busy, ready, zero, carry;

    // Regression instance, PULSE_CYCLES = 1
    logic       rst1 = 1'b1, req1 = 1'b0, dec1 = 1'b0, set1 = 1'b0;
    logic [9:0] din1 = '0;
    logic [9:0] out1;
    logic [1:0] guide1;
    logic       busy1, ready1, zero1, carry1;

    dekatron_step #(.PULSE_CYCLES(P)) u_dut (
        .Clk(clk), .Rst(rst), .Request(req), .Dec(dec), .Set(set), .In(din),
        .Out(out), .Guide(guide), .Busy(busy), .Ready(ready), .Zero(zero), .Carry(carry)
    );

    dekatron_step #(.PULSE_CYCLES(1)) u_dut1 (
        .Clk(clk), .Rst(rst1), .Request(req1), .Dec(dec1), .Set(set1), .In(din1),
        .Out(out1), .Guide(guide1), .Busy(busy1), .Ready(ready1), .Zero(zero1), .Carry(carry1)
    );

    int vectors = 0;
    int miscompares = 0;
    int pos_m = 0;   // reference glow position as an index 0..9

    logic [14:0] obs;
    assign obs = {out, guide, busy, ready, zero, carry};

    // Reference observation: {Out, Guide, Busy, Ready, Zero, Carry}
    function automatic logic [14:0] expv(input int p, input logic [1:0] g,
                                         input logic b, input logic r, input logic c);
        logic [9:0] oh;
        oh = 10'd1 << p;
        return {oh, g, b, r, (p == 0), c};
    endfunction

    function automatic int load_index(input logic [9:0] v);
        int idx;
        idx = 0;
        if ($countones(v) == 1)
            for (int k = 0; k < 10; k++)
                if (v[k]) idx = k;
        return idx;
    endfunction

    task automatic test_reset();
        rst = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs !== expv(0, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", obs, expv(0, 2'b00, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0; rst1 = 1'b0; pos_m = 0;
        @(negedge clk);
        vectors++;
        if (obs !== expv(0, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", obs, expv(0, 2'b00, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // One full step on the P=4 instance, checked every cycle. With noise set,
    // Request and Set are pulsed for one cycle during the second guide phase.
    task automatic run_step(input logic d, input bit noise, input logic [9:0] nin,
                            input string name);
        logic [1:0] gexp;
        logic       w;
        int         np;
        @(negedge clk);
        req = 1'b1; dec = d; set = 1'b0;
        @(negedge clk);
        req = 1'b0; dec = 1'($urandom);
        for (int i = 0; i < 2 * P; i++) begin
            if (i > 0) @(negedge clk);
            gexp = ((i < P) ^ d) ? 2'b01 : 2'b10;
            vectors++;
            if (obs !== expv(pos_m, gexp, 1'b1, 1'b0, 1'b0)) begin
                miscompares++;
                $display("FAIL %s_phase%0d: got %h want %h", name, i, obs,
                         expv(pos_m, gexp, 1'b1, 1'b0, 1'b0));
            end
            req = 1'b0; set = 1'b0;
            if (noise && i == P) begin
                req = 1'b1; set = 1'b1; din = nin; dec = 1'($urandom);
            end
            else dec = 1'($urandom);
        end
        np = d ? (pos_m + 9) % 10 : (pos_m + 1) % 10;
        w  = d ? (pos_m == 0) : (pos_m == 9);
        pos_m = np;
        @(negedge clk);
        vectors++;
        if (obs !== expv(pos_m, 2'b00, 1'b0, 1'b1, w)) begin
            miscompares++;
            $display("FAIL %s_done: got %h want %h", name, obs, expv(pos_m, 2'b00, 1'b0, 1'b1, w));
        end
        @(negedge clk);
        vectors++;
        if (obs !== expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL %s_idle: got %h want %h", name, obs, expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic do_load(input logic [9:0] v, input logic with_req, input string name);
        @(negedge clk);
        set = 1'b1; din = v; req = with_req; dec = 1'($urandom);
        @(negedge clk);
        set = 1'b0; req = 1'b0;
        pos_m = load_index(v);
        vectors++;
        if (obs !== expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, obs, expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        vectors++;
        if (obs !== expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL %s_hold: got %h want %h", name, obs, expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0));
        end
    endtask

    task automatic test_increment();
        run_step(1'b0, 1'b0, '0, "inc");
    endtask

    task automatic test_carry();
        do_load(10'h200, 1'b0, "load_nine");
        run_step(1'b0, 1'b0, '0, "wrap_inc");
        run_step(1'b1, 1'b0, '0, "wrap_dec");
    endtask

    task automatic test_busy_guard();
        do_load(10'h008, 1'b0, "load_three");
        run_step(1'b0, 1'b1, 10'h010, "busy_guard");
    endtask

    task automatic test_loads();
        do_load(10'h028, 1'b0, "load_two_bits");
        do_load(10'h000, 1'b0, "load_empty");
        do_load(10'h080, 1'b1, "set_with_req");
    endtask

    task automatic test_reset_mid();
        do_load(10'h040, 1'b0, "load_six");
        @(negedge clk);
        req = 1'b1; dec = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        pos_m = 0;
        vectors++;
        if (obs !== expv(0, 2'b00, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL rst_mid_async: got %h want %h", obs, expv(0, 2'b00, 1'b0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_p1_regression();
        int carries, readys, exp_pos;
        logic [9:0] eoh;
        @(negedge clk);
        req1 = 1'b1; dec1 = 1'b0;
        @(negedge clk);
        req1 = 1'b0;
        vectors++;
        if (guide1 !== 2'b01) begin
            miscompares++;
            $display("FAIL p1_ph1_guide: got %b want 01", guide1);
        end
        #2 rst1 = 1'b1;
        #1;
        vectors++;
        if ({out1, guide1, busy1, ready1, zero1, carry1} !== {10'h001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL p1_rst_mid: got %h want %h", {out1, guide1, busy1, ready1, zero1, carry1},
                     {10'h001, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0});
        end
        @(negedge clk);
        rst1 = 1'b0;
        carries = 0; readys = 0; exp_pos = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req1 = 1'b1; dec1 = 1'b0;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                req1 = 1'b0;
                if (carry1) carries++;
                if (ready1) readys++;
                if (j == 2) begin
                    exp_pos = (exp_pos + 1) % 10;
                    eoh = 10'd1 << exp_pos;
                    vectors++;
                    if (out1 !== eoh || ready1 !== 1'b1) begin
                        miscompares++;
                        $display("FAIL p1_step%0d: got out=%h ready=%b want out=%h ready=1",
                                 k, out1, ready1, eoh);
                    end
                end
            end
        end
        vectors++;
        if (out1 !== 10'h001 || carries != 1 || readys != 10) begin
            miscompares++;
            $display("FAIL p1_loop: got out=%h carries=%0d readys=%0d want out=001 carries=1 readys=10",
                     out1, carries, readys);
        end
    endtask

    task automatic test_random();
        int op;
        logic [9:0] v;
        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                run_step(1'($urandom), 1'b0, '0, "rand_step");
            end else if (op == 1) begin
                if ($urandom_range(0, 1) == 1) v = 10'd1 << $urandom_range(0, 9);
                else v = 10'($urandom);
                do_load(v, 1'($urandom), "rand_load");
            end else begin
                @(negedge clk);
                req = 1'b0; set = 1'b0; din = 10'($urandom); dec = 1'($urandom);
                vectors++;
                if (obs !== expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0)) begin
                    miscompares++;
                    $display("FAIL rand_idle: got %h want %h", obs, expv(pos_m, 2'b00, 1'b0, 1'b0, 1'b0));
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_increment();
        test_carry();
        test_busy_guard();
        test_loads();
        test_reset_mid();
        test_p1_regression();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
